// File: rtl/cobs_decoder_if.sv
// AXI-Stream style byte channel shared by the COBS receive path.
// master/slave are the generic views; Source/Sink are the views the decoder
// uses. Sink leaves out tlast because the decoder ignores upstream framing.
interface axis_interface #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

    modport Source (output tvalid, output tdata, output tlast, input tready);
    modport Sink   (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cobs_decoder.sv
// COBS receive decoder: strips COBS framing from the FT232H byte stream and
// emits payload bytes with tlast on the final byte of each frame.
// Every decoded byte waits in a hold register until the next input event
// shows whether it is the last byte of its frame.
module cobs_decoder (
    input  logic          clk,
    input  logic          rst,
    axis_interface.Sink   encoded_stream,
    axis_interface.Source decoded_stream,
    output logic          frame_error
);

    typedef enum logic {
        CODE,
        DATA
    } state_t;

    state_t      state, state_next;
    logic [7:0]  remaining, remaining_next;
    logic        zero_pending, zero_pending_next;
    logic        hold_valid, hold_valid_next;
    logic [7:0]  hold_data, hold_data_next;
    logic        out_valid, out_valid_next;
    logic [7:0]  out_data, out_data_next;
    logic        out_last, out_last_next;
    logic        frame_error_next;

    logic        in_accept;
    logic [7:0]  in_byte;
    logic        push;
    logic [7:0]  push_byte;
    logic        flush;

    // Upstream may advance whenever the hold byte has somewhere to go.
    assign encoded_stream.tready = !rst && (!hold_valid || !out_valid || decoded_stream.tready);
    assign in_accept = encoded_stream.tvalid && encoded_stream.tready;
    assign in_byte   = encoded_stream.tdata;

    assign decoded_stream.tvalid = out_valid;
    assign decoded_stream.tdata  = out_data;
    assign decoded_stream.tlast  = out_last;

    // Decode each accepted byte into at most one push or a flush, and advance the block state.
    always_comb begin
        state_next        = state;
        remaining_next    = remaining;
        zero_pending_next = zero_pending;
        frame_error_next  = 1'b0;
        push              = 1'b0;
        push_byte         = 8'h00;
        flush             = 1'b0;

        if (in_accept) begin
            case (state)
                CODE: begin
                    if (in_byte == 8'h00) begin
                        flush             = 1'b1;
                        zero_pending_next = 1'b0;
                    end else begin
                        if (zero_pending) begin
                            push      = 1'b1;
                            push_byte = 8'h00;
                        end
                        remaining_next    = in_byte - 8'd1;
                        zero_pending_next = (in_byte != 8'hFF);
                        state_next        = (in_byte > 8'd1) ? DATA : CODE;
                    end
                end
                DATA: begin
                    if (in_byte == 8'h00) begin
                        flush             = 1'b1;
                        frame_error_next  = 1'b1;
                        zero_pending_next = 1'b0;
                        state_next        = CODE;
                    end else begin
                        push           = 1'b1;
                        push_byte      = in_byte;
                        remaining_next = remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state_next = CODE;
                        end
                    end
                end
                default: state_next = CODE;
            endcase
        end
    end

    // Move bytes hold -> output on push/flush and retire the output on downstream accept.
    always_comb begin
        hold_valid_next = hold_valid;
        hold_data_next  = hold_data;
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        out_last_next   = out_last;

        if (out_valid && decoded_stream.tready) begin
            out_valid_next = 1'b0;
        end

        if (push) begin
            if (hold_valid) begin
                out_valid_next = 1'b1;
                out_data_next  = hold_data;
                out_last_next  = 1'b0;
            end
            hold_valid_next = 1'b1;
            hold_data_next  = push_byte;
        end else if (flush && hold_valid) begin
            out_valid_next  = 1'b1;
            out_data_next   = hold_data;
            out_last_next   = 1'b1;
            hold_valid_next = 1'b0;
        end
    end

    // State and staging registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CODE;
            remaining    <= 8'd0;
            zero_pending <= 1'b0;
            hold_valid   <= 1'b0;
            hold_data    <= 8'h00;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            out_last     <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            remaining    <= remaining_next;
            zero_pending <= zero_pending_next;
            hold_valid   <= hold_valid_next;
            hold_data    <= hold_data_next;
            out_valid    <= out_valid_next;
            out_data     <= out_data_next;
            out_last     <= out_last_next;
            frame_error  <= frame_error_next;
        end
    end

endmodule
